// File: rtl/sine_width_gen.sv
// Sine duty-cycle source: steps a phase accumulator once per PWM period and
// precomputes the next high-time from a quarter-wave ROM, committing it on tick.
module sine_width_gen #(
    parameter int unsigned PERIOD   = 1000,
    parameter int unsigned ADDR_W   = 6,
    parameter string       ROM_FILE = "sine_quarter.mem"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        tick,
    input  logic [31:0] phase_inc,
    output logic [31:0] width_sine,
    output logic        width_valid,
    output logic        underrun
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned HALF   = PERIOD / 2;
    localparam int unsigned AMP    = HALF - 1;
    localparam logic [31:0] HALF_W = 32'(HALF);
    localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

    typedef enum logic [1:0] {ADDR, READ, CALC, READY} state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic [31:0]         phase;
    logic [1:0]          quad;
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         q;
    logic [31:0]         shadow;
    logic [31:0]         rom [DEPTH];

    // round(AMP * sin(pi/2 * (k+0.5)/DEPTH)) in Q60 fixed point (Taylor series).
    function automatic logic [127:0] rom_entry(input int unsigned k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] acc;
        x    = (PI_Q60 * 128'(2 * k + 1)) / 128'(4 * DEPTH);
        x2   = (x * x) >> 60;
        term = x;
        acc  = x;
        for (int unsigned n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if (n[0]) acc = acc - term;
            else      acc = acc + term;
        end
        return (128'(AMP) * acc + (128'd1 << 59)) >> 60;
    endfunction

    // Table is derived from PERIOD/ADDR_W by the same formula that produces
    // ROM_FILE, so no init file has to travel with the design.
    if (ROM_FILE == "") begin : g_no_rom_file
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [31:0] ENTRY = 32'(rom_entry(k));
        assign rom[k] = ENTRY;
    end

    always_comb accept = tick & enable;

    always_ff @(posedge clk) begin
        if (rst) state <= ADDR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ADDR:    state_next = READ;
            READ:    state_next = CALC;
            CALC:    state_next = READY;
            READY:   if (accept) state_next = ADDR;
            default: state_next = ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            quad        <= '0;
            addr        <= '0;
            q           <= '0;
            shadow      <= HALF_W;
            width_sine  <= HALF_W;
            width_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            width_valid <= 1'b0;
            unique case (state)
                ADDR: begin
                    quad <= phase[31:30];
                    // Odd quadrants run the quarter wave backwards.
                    addr <= phase[30] ? ~phase[29 -: ADDR_W] : phase[29 -: ADDR_W];
                end
                READ: q <= rom[addr];
                CALC: shadow <= quad[1] ? HALF_W - q : HALF_W + q;
                READY: begin
                    if (accept) begin
                        width_sine  <= shadow;
                        phase       <= phase + phase_inc;
                        width_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (accept && state != READY) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sine_width_gen.sv
// Scoreboard bench for sine_width_gen: the driver queues expected commits,
// a negedge monitor pops and compares on every width_valid pulse.
module tb_sine_width_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tick;
    logic [31:0] phase_inc;
    logic [31:0] width_sine;
    logic        width_valid;
    logic        underrun;

    typedef struct {
        int unsigned width;
        int unsigned cyc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    exp_t        sb[$];
    int unsigned seen[$];
    logic [31:0] m_phase;
    int unsigned last_w;

    sine_width_gen #(
        .PERIOD  (1000),
        .ADDR_W  (6),
        .ROM_FILE("sine_quarter.mem")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick       (tick),
        .phase_inc  (phase_inc),
        .width_sine (width_sine),
        .width_valid(width_valid),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent real-valued reference for PERIOD=1000, 64-entry quarter wave.
    function automatic int unsigned model_width(input logic [31:0] ph);
        int unsigned a;
        int unsigned qi;
        real         qr;
        a = 32'(ph[29:24]);
        if (ph[30]) a = 63 - a;
        qr = $floor(499.0 * $sin(3.14159265358979 / 2.0 * (real'(a) + 0.5) / 64.0) + 0.5);
        qi = 32'($rtoi(qr));
        return ph[31] ? 500 - qi : 500 + qi;
    endfunction

    always @(negedge clk) begin
        if (width_valid === 1'b1) begin
            seen.push_back(width_sine);
            check("scoreboard has entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("committed width", 64'(width_sine), 64'(e.width));
                check("width_valid cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic do_tick(input bit commit, input int unsigned exp_w, input int gap);
        exp_t e;
        tick = 1'b1;
        if (commit) begin
            e.width = exp_w;
            e.cyc   = cyc + 1;
            sb.push_back(e);
            last_w  = exp_w;
        end
        @(negedge clk);
        tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic tick_commit(input int gap);
        int unsigned w;
        w = model_width(m_phase);
        do_tick(1'b1, w, gap);
        m_phase = m_phase + phase_inc;
    endtask

    initial begin
        int unsigned hand[5];
        hand = '{506, 999, 494, 1, 506};
        rst = 1'b1; enable = 1'b1; tick = 1'b0; phase_inc = '0; m_phase = '0; last_w = 500;

        // Reset, with a tick coincident with the last reset edge.
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
        check("reset width_sine", 64'(width_sine), 64'd500);
        check("reset underrun", 64'(underrun), 64'd0);
        check("reset width_valid", 64'(width_valid), 64'd0);
        check("reset phase", 64'(dut.phase), 64'd0);
        repeat (2) @(negedge clk);
        check("shadow before READY", 64'(dut.shadow), 64'd500);
        @(negedge clk);
        check("shadow at READY", 64'(dut.shadow), 64'd506);

        // Quarter steps: hand-computed mirror/sign sequence.
        phase_inc = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            do_tick(1'b1, hand[i], 999);
            m_phase = m_phase + phase_inc;
        end
        check("no underrun at wide spacing", 64'(underrun), 64'd0);

        // Full sweep, two sine periods through the phase wrap.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_phase = '0;
        repeat (3) @(negedge clk);
        phase_inc = 32'h0400_0000;
        seen.delete();
        for (int i = 0; i < 128; i++) tick_commit(7);
        repeat (4) @(negedge clk);
        check("sweep commit count", 64'(seen.size()), 64'd128);
        if (seen.size() >= 128) begin
            check("sweep n=0", 64'(seen[0]), 64'd506);
            check("sweep n=16", 64'(seen[16]), 64'd999);
            check("sweep n=32", 64'(seen[32]), 64'd494);
            check("sweep n=48", 64'(seen[48]), 64'd1);
            for (int n = 0; n < 32; n++)
                check($sformatf("symmetry n=%0d", n), 64'(seen[n] + seen[n + 32]), 64'd1000);
            for (int n = 0; n < 64; n++)
                check($sformatf("repeat n=%0d", n), 64'(seen[n + 64]), 64'(seen[n]));
        end

        // Two ticks two cycles apart: second must underrun.
        tick_commit(1);
        do_tick(1'b0, 0, 0);
        check("underrun hold width", 64'(width_sine), 64'(last_w));
        check("underrun hold phase", 64'(dut.phase), 64'(m_phase));
        check("underrun set", 64'(underrun), 64'd1);
        repeat (6) @(negedge clk);
        tick_commit(8);
        check("underrun sticky", 64'(underrun), 64'd1);

        // Enable low across three ticks, dropped mid-precompute.
        tick_commit(0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_tick(1'b0, 0, 8);
            check("disabled width", 64'(width_sine), 64'(last_w));
            check("disabled phase", 64'(dut.phase), 64'(m_phase));
        end
        enable = 1'b1;
        tick_commit(8);

        // Reset one cycle after a tick, mid-precompute.
        tick_commit(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_phase = '0;
        check("mid reset width", 64'(width_sine), 64'd500);
        check("mid reset phase", 64'(dut.phase), 64'd0);
        check("mid reset underrun", 64'(underrun), 64'd0);
        repeat (4) @(negedge clk);
        do_tick(1'b1, 506, 8);

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
